// File: rtl/fir_ys_fifo.sv
// fir_ys_fifo
// Output-side buffer for the FIR y[n] stream. A first-word-fall-through FIFO
// holds y samples together with their tlast flag. It decouples the FIR from
// back-pressure on the consumer side. Each frame's sample count is checked
// against cfg_length.
//
// Ports
//   axis_clk, axis_rst_n         clock, asynchronous active-low reset
//   s_tvalid/s_tdata/s_tlast     y sample stream from the FIR master
//   s_tready                     FIFO not full
//   m_tvalid/m_tdata/m_tlast     buffered stream to the consumer
//   m_tready                     consumer ready
//   cfg_length                   expected samples per frame (0 = no check)
//   err_clr                      clears len_err
//   level                        occupancy, 0..depth
//   frame_done                   one-cycle pulse after a tlast sample is accepted
//   len_err                      sticky frame-length mismatch
module fir_ys_fifo #(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH_LOG2 = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   s_tvalid,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic                   m_tvalid,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready,
  input  logic [31:0]            cfg_length,
  input  logic                   err_clr,
  output logic [pDEPTH_LOG2:0]   level,
  output logic                   frame_done,
  output logic                   len_err
);

  localparam int DEPTH = 1 << pDEPTH_LOG2;

  // Each entry is {last, data}. The array is not reset, because only
  // entries between rd_ptr and wr_ptr are ever observed.
  logic [pDATA_WIDTH:0]   mem [DEPTH];
  logic [pDEPTH_LOG2:0]   wr_ptr;
  logic [pDEPTH_LOG2:0]   rd_ptr;
  logic [pDATA_WIDTH:0]   rd_entry;
  logic                   empty;
  logic                   full;
  logic                   push;
  logic                   pop;

  logic [31:0]            frm_cnt;
  logic [31:0]            frm_next;
  logic                   err_now;

  // The extra pointer MSB tells full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[pDEPTH_LOG2-1:0] == rd_ptr[pDEPTH_LOG2-1:0]) &&
                 (wr_ptr[pDEPTH_LOG2] != rd_ptr[pDEPTH_LOG2]);
  assign level = wr_ptr - rd_ptr;

  // s_tready ignores m_tready. A full FIFO therefore never takes a sample
  // in the same cycle that it pops one.
  assign s_tready = ~full;
  assign m_tvalid = ~empty;
  assign push     = s_tvalid & s_tready;
  assign pop      = m_tvalid & m_tready;

  assign rd_entry = mem[rd_ptr[pDEPTH_LOG2-1:0]];
  assign m_tdata  = empty ? '0   : rd_entry[pDATA_WIDTH-1:0];
  assign m_tlast  = empty ? 1'b0 : rd_entry[pDATA_WIDTH];

  // Length check: a tlast push must complete exactly cfg_length samples.
  // A non-tlast push must not reach cfg_length.
  assign frm_next = frm_cnt + 32'd1;
  assign err_now  = push && (cfg_length != 32'd0) &&
                    (s_tlast ? (frm_next != cfg_length) : (frm_next == cfg_length));

  // ---- stage p0 -> p1: storage write and pointer update ----
  always_ff @(posedge axis_clk) begin
    if (push) begin
      mem[wr_ptr[pDEPTH_LOG2-1:0]] <= {s_tlast, s_tdata};
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---- stage p0 -> p1: frame accounting and status ----
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      frm_cnt    <= '0;
      frame_done <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      frame_done <= push & s_tlast;
      if (push) begin
        frm_cnt <= s_tlast ? 32'd0 : frm_next;
      end
      // A new error takes priority over a simultaneous clear.
      if (err_now) begin
        len_err <= 1'b1;
      end else if (err_clr) begin
        len_err <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fir_ys_fifo.md
# fir_ys_fifo

Output-side buffer that sits directly downstream of the FIR stream master (y[n] port) and decouples the FIR from the consumer's back-pressure. It stores y samples with their tlast flag in a small first-word-fall-through FIFO and checks each frame's sample count against the configured data length. It reports frame completion and a sticky length-error flag to the block-level control.

## Interface
- pDATA_WIDTH, 32, width of y samples
- pDEPTH_LOG2, 4, log2 of FIFO depth (depth = 16 by default)
- axis_clk  in  1  clock
- axis_rst_n  in  1  asynchronous, active-low reset
- s_tvalid  in  1  y sample valid (from FIR sm_tvalid)
- s_tdata  in  pDATA_WIDTH  y sample
- s_tlast  in  1  last sample of frame
- s_tready  out  1  FIFO can accept (to FIR sm_tready)
- m_tvalid  out  1  output sample valid
- m_tdata  out  pDATA_WIDTH  output sample
- m_tlast  out  1  output last flag
- m_tready  in  1  consumer ready
- cfg_length  in  32  expected samples per frame; 0 disables the check
- err_clr  in  1  clears len_err (single-cycle pulse)
- level  out  pDEPTH_LOG2+1  current occupancy, 0..depth
- frame_done  out  1  one-cycle pulse when a tlast sample is accepted
- len_err  out  1  sticky frame-length mismatch

## Operation
- Storage: depth × (pDATA_WIDTH+1) register array (data + last). Array contents are not reset.
- Pointers wr_ptr and rd_ptr are each pDEPTH_LOG2+1 bits, with an extra wrap bit. empty = (wr_ptr == rd_ptr). full = low bits equal and wrap bits differ. level = wr_ptr − rd_ptr.
- push = s_tvalid & s_tready. pop = m_tvalid & m_tready.
- s_tready = ~full, combinational from registered state. It does not depend on m_tready, so no pass-through when full.
- m_tvalid = ~empty. When not empty, m_tdata and m_tlast show the entry at rd_ptr; when empty, both are 0.
- Push and pop in the same cycle: both pointers advance and level is unchanged. This is legal at any non-full, non-empty level. When empty, only the push happens.
- Pointers wrap naturally modulo 2·depth.
- Frame counter frm_cnt (32-bit):
  - increments on each push without tlast;
  - returns to 0 on a push with tlast.
- Length check, only when cfg_length ≠ 0. len_err sets on either:
  - a push with tlast where frm_cnt+1 ≠ cfg_length (short or long frame);
  - a push without tlast where frm_cnt+1 == cfg_length (missing tlast).
- Only the first error needs recording. len_err stays set until err_clr.
- err_clr and a new error in the same cycle: the error wins and len_err stays 1.
- frame_done: asserted the cycle after a push with tlast, for exactly one cycle, regardless of error.
- cfg_length is sampled at each push. Changing it mid-frame applies from the next push.

## Timing
- Reset values: s_tready=1, m_tvalid=0, m_tdata=0, m_tlast=0, level=0, frame_done=0, len_err=0. Pointers and frm_cnt are 0.
- Latency: a sample pushed at edge N is visible on m_tvalid/m_tdata after edge N, i.e. one cycle of latency into an empty FIFO.
- Throughput: one sample per cycle in and out sustained.
- AXI-stream rules on the m side: once m_tvalid=1, m_tdata/m_tlast hold stable until pop. m_tvalid never drops without a pop.
- Reset mid-operation discards all contents and the in-progress frame count. Outputs return to reset values asynchronously.
- len_err updates on the edge of the offending push and is visible the following cycle.

## Test plan
- Fill/drain: hold m_tready=0 and push 0x1..0x10. s_tready drops after 16 accepts and level=16. Then m_tready=1: outputs 0x1..0x10 in order, one per cycle, and level returns to 0.
- Streaming: s_tvalid=1 and m_tready=1 continuously with data 0..99. Output equals input delayed one cycle, level stays at most 1, no bubbles.
- Random back-pressure: 600 samples with random s_tvalid and m_tready at 50%. Output sequence is identical to input, tlast bits preserved, and level matches a reference model every cycle.
- Frame check OK: cfg_length=600, 600 samples with tlast on the last. frame_done pulses once, len_err=0, frm_cnt returns to 0.
- Frame errors:
  - cfg_length=8 with tlast on sample 5 → len_err=1 the cycle after sample 5.
  - err_clr → len_err=0.
  - 9 samples with tlast on the 9th → len_err=1 at sample 8.
  - cfg_length=0 → no error for any frame length.
- Async reset with level=7 mid-frame: outputs return to reset values immediately, and the next frame of 8 with cfg_length=8 passes with no len_err.
